simon_round_sequencer: RTL and testbench

- Round controller for the memory-game datapath.
- Each round it requests one new 2-bit symbol from the random generator and appends it to an internal pattern buffer.
- It then plays the whole pattern back on the LED/display outputs and checks the player's button presses against it.
- Declares win at MAX_LEN correct symbols; declares lose on a wrong symbol or an input timeout.

---
 rtl/simon_round_sequencer.sv | 161 ++++++++++++++++
 tb/tb_simon_round_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_sequencer.sv
// Round controller for the memory game: grows a random 2-bit pattern by one
// symbol per round, plays it back on the LEDs and checks the player's presses.
module simon_round_sequencer #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned STEP_TICKS    = 25000000,
  parameter int unsigned GAP_TICKS     = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 250000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] rand_in,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  output logic       rand_go,
  output logic       led_on,
  output logic [1:0] led_code,
  output logic       input_phase,
  output logic [5:0] score,
  output logic       win,
  output logic       lose
);

  localparam int unsigned IW   = $clog2(MAX_LEN) + 1;
  localparam int unsigned AW   = $clog2(MAX_LEN);
  localparam int unsigned T01  = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
  localparam int unsigned TMAX = (T01 > TIMEOUT_TICKS) ? T01 : TIMEOUT_TICKS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [IW-1:0] LEN_MAX   = IW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] len, play_idx, in_idx;
  logic [TW-1:0] timer;
  logic [1:0]    mem [MAX_LEN];

  logic timer_zero, press_hit, last_in, last_play;

  assign timer_zero = (timer == '0);
  assign press_hit  = btn_valid && (btn_code == mem[in_idx[AW-1:0]]);
  assign last_in    = (in_idx == len - IW'(1));
  assign last_play  = (play_idx == len - IW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_GEN;
      S_GEN:      state_nxt = S_SHOW_ON;
      S_SHOW_ON:  if (timer_zero) state_nxt = S_SHOW_OFF;
      S_SHOW_OFF: if (timer_zero) state_nxt = last_play ? S_INPUT : S_SHOW_ON;
      S_INPUT: begin
        // a press on the final timeout cycle takes priority over the timeout
        if (btn_valid) begin
          if (!press_hit)   state_nxt = S_LOSE;
          else if (last_in) state_nxt = (len == LEN_MAX) ? S_WIN : S_GEN;
        end else if (timer_zero) begin
          state_nxt = S_LOSE;
        end
      end
      S_WIN, S_LOSE: if (start) state_nxt = S_GEN;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len      <= '0;
      play_idx <= '0;
      in_idx   <= '0;
      timer    <= '0;
      score    <= '0;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            len   <= '0;
            score <= '0;
          end
        end
        S_GEN: begin
          len      <= len + IW'(1);
          play_idx <= '0;
          timer    <= STEP_LOAD;
        end
        S_SHOW_ON: begin
          if (timer_zero) timer <= GAP_LOAD;
          else            timer <= timer - TW'(1);
        end
        S_SHOW_OFF: begin
          if (timer_zero) begin
            if (last_play) begin
              in_idx <= '0;
              timer  <= TO_LOAD;
            end else begin
              play_idx <= play_idx + IW'(1);
              timer    <= STEP_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_INPUT: begin
          if (btn_valid) begin
            if (press_hit) begin
              timer <= TO_LOAD;
              if (last_in) score  <= 6'(len);
              else         in_idx <= in_idx + IW'(1);
            end
          end else if (!timer_zero) begin
            timer <= timer - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pattern storage carries no reset; entries are only read below len.
  always_ff @(posedge clk) begin
    if (state == S_GEN) mem[len[AW-1:0]] <= rand_in;
  end

  always_comb begin
    rand_go     = 1'b0;
    led_on      = 1'b0;
    led_code    = '0;
    input_phase = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;
    case (state)
      S_GEN:     rand_go = 1'b1;
      S_SHOW_ON: begin
        led_on   = 1'b1;
        led_code = mem[play_idx[AW-1:0]];
      end
      S_INPUT:   input_phase = 1'b1;
      S_WIN:     win = 1'b1;
      S_LOSE:    lose = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Directed-plus-random bench for simon_round_sequencer; expected traces come
// from a pattern queue and the playback/timeout rules.
module tb_simon_round_sequencer;

  localparam int unsigned ML = 3;
  localparam int unsigned ST = 3;
  localparam int unsigned GT = 2;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rand_in = '0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_code = '0;
  logic       rand_go, led_on, input_phase, win, lose;
  logic [1:0] led_code;
  logic [5:0] score;

  int checks = 0;
  int errors = 0;
  logic [1:0] pat [$];
  int exp_score = 0;
  logic [1:0] wrong;

  always #5 clk = ~clk;

  simon_round_sequencer #(
    .MAX_LEN(ML),
    .STEP_TICKS(ST),
    .GAP_TICKS(GT),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .rand_in(rand_in),
    .btn_valid(btn_valid),
    .btn_code(btn_code),
    .rand_go(rand_go),
    .led_on(led_on),
    .led_code(led_code),
    .input_phase(input_phase),
    .score(score),
    .win(win),
    .lose(lose)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // control vector = {rand_go, led_on, led_code, input_phase, win, lose}
  task automatic chk_outs(input string tag, input bit go, input bit led, input logic [1:0] code,
                          input bit inp, input bit w, input bit l, input int sc);
    chk({tag, "_ctl"}, {1'b0, rand_go, led_on, led_code, input_phase, win, lose},
        {1'b0, go, led, code, inp, w, l});
    chk({tag, "_score"}, {2'b00, score}, {2'b00, 6'(sc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while the DUT is expected in the generate cycle.
  task automatic run_round(input logic [1:0] sym, input bit inject);
    chk_outs("gen", 1, 0, 2'd0, 0, 0, 0, exp_score);
    rand_in = sym;
    pat.push_back(sym);
    step();
    rand_in = 2'($urandom);
    for (int i = 0; i < pat.size(); i++) begin
      for (int t = 0; t < int'(ST); t++) begin
        chk_outs("show_on", 0, 1, pat[i], 0, 0, 0, exp_score);
        if (inject && i == 0 && t == 0) begin
          start     = 1'b1;
          btn_valid = 1'b1;
          btn_code  = 2'($urandom);
        end
        step();
        start     = 1'b0;
        btn_valid = 1'b0;
      end
      for (int t = 0; t < int'(GT); t++) begin
        chk_outs("show_off", 0, 0, 2'd0, 0, 0, 0, exp_score);
        step();
      end
    end
    chk_outs("input", 0, 0, 2'd0, 1, 0, 0, exp_score);
  endtask

  task automatic press(input int nw, input logic [1:0] code, input bit inj_start);
    for (int w = 0; w < nw; w++) begin
      chk_outs("wait", 0, 0, 2'd0, 1, 0, 0, exp_score);
      if (inj_start && w == 0) start = 1'b1;
      step();
      start = 1'b0;
    end
    btn_valid = 1'b1;
    btn_code  = code;
    step();
    btn_valid = 1'b0;
  endtask

  task automatic play_correct();
    for (int i = 0; i < pat.size(); i++) begin
      press(int'($urandom_range(0, TO - 1)), pat[i], i == 0);
      if (i < pat.size() - 1) chk_outs("inp_cont", 0, 0, 2'd0, 1, 0, 0, exp_score);
    end
    exp_score = pat.size();
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    pat.delete();
    exp_score = 0;
  endtask

  initial begin
    logic [1:0] syms [3];
    syms[0] = 2'd2;
    syms[1] = 2'd1;
    syms[2] = 2'd3;

    #2 reset_n = 1'b0;
    #1 chk_outs("reset", 0, 0, 2'd0, 0, 0, 0, 0);
    #20 reset_n = 1'b1;
    step();
    chk_outs("idle", 0, 0, 2'd0, 0, 0, 0, 0);
    btn_valid = 1'b1;
    btn_code  = 2'd1;
    step();
    btn_valid = 1'b0;
    chk_outs("idle_btn", 0, 0, 2'd0, 0, 0, 0, 0);

    // game 1: fixed symbols 2,1,3 to a win
    new_game();
    for (int r = 0; r < 3; r++) begin
      run_round(syms[r], r == 1);
      play_correct();
    end
    chk_outs("win", 0, 0, 2'd0, 0, 1, 0, ML);
    for (int k = 0; k < 3; k++) begin
      btn_valid = 1'b1;
      btn_code  = 2'($urandom);
      step();
      btn_valid = 1'b0;
      chk_outs("win_hold", 0, 0, 2'd0, 0, 1, 0, ML);
    end

    // game 2: wrong symbol in round 2
    new_game();
    run_round(2'($urandom), 1'b0);
    play_correct();
    run_round(2'($urandom), 1'b1);
    press(int'($urandom_range(0, TO - 1)), pat[0], 1'b0);
    chk_outs("inp_cont2", 0, 0, 2'd0, 1, 0, 0, exp_score);
    wrong = pat[1] + 2'd1;
    press(int'($urandom_range(0, TO - 1)), wrong, 1'b0);
    chk_outs("lose_wrong", 0, 0, 2'd0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      btn_valid = 1'b1;
      btn_code  = pat[k % 2];
      step();
      btn_valid = 1'b0;
      chk_outs("lose_hold", 0, 0, 2'd0, 0, 0, 1, 1);
    end

    // game 3: press on the last allowed cycle, then a timeout
    new_game();
    run_round(2'($urandom), 1'b0);
    press(int'(TO) - 1, pat[0], 1'b1);
    exp_score = 1;
    run_round(2'($urandom), 1'b0);
    for (int w = 0; w < int'(TO); w++) begin
      chk_outs("to_wait", 0, 0, 2'd0, 1, 0, 0, exp_score);
      step();
    end
    chk_outs("lose_timeout", 0, 0, 2'd0, 0, 0, 1, 1);

    // game 4: reset during playback
    new_game();
    chk_outs("gen4", 1, 0, 2'd0, 0, 0, 0, 0);
    rand_in = 2'd3;
    step();
    chk_outs("show4", 0, 1, 2'd3, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk_outs("async_reset", 0, 0, 2'd0, 0, 0, 0, 0);
    step();
    #3 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_outs("idle_after_rst", 0, 0, 2'd0, 0, 0, 0, 0);
    end

    // game 5: random symbols to a win
    new_game();
    for (int r = 0; r < 3; r++) begin
      run_round(2'($urandom), 1'b1);
      play_correct();
    end
    chk_outs("win5", 0, 0, 2'd0, 0, 1, 0, ML);
    new_game();
    chk_outs("restart", 1, 0, 2'd0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
